// File: rtl/mux_pair_gather_pkg.sv
// mux_pair_gather_pkg: shared constants for the A/B beat re-pairing block.
package mux_pair_gather_pkg;
    localparam int BEAT_W = 8;
    localparam int FIFO_DEPTH = 4;
    localparam logic PH_A = 1'b0;
    localparam logic PH_B = 1'b1;
endpackage

// File: rtl/mux_pair_gather_sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-through FIFO; a push into a full FIFO succeeds when a pop frees the slot.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             push_ok_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic pop_ok;
    assign empty_o = wr_q == rd_q;
    assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok = pop_i && !empty_o;
    assign push_ok_o = push_i && (!full_o || pop_ok);
    assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    always_comb begin
        wr_d = push_ok_o ? wr_q + 1'b1 : wr_q;
        rd_d = pop_ok ? rd_q + 1'b1 : rd_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/mux_pair_gather.sv
// mux_pair_gather: tracks the upstream 2:1 mux phase, re-pairs A/B beats into {B,A}
// words and queues them in a first-word-through FIFO with valid/ready output.
module mux_pair_gather
    import mux_pair_gather_pkg::*;
#(
    parameter int N = BEAT_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     data_in,
    output logic [2*N-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             orphan,
    output logic [CNT_W-1:0] pair_count
);
    logic phase_q, phase_d;
    logic [N-1:0] hold_q, hold_d;
    logic overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic push, push_ok, full, empty;
    assign push = enable && phase_q == PH_B;
    // An A beat left waiting when enable drops is the orphan case.
    assign orphan = !enable && phase_q == PH_B;
    assign out_valid = !empty;
    assign overflow = overflow_q;
    assign pair_count = cnt_q;
    always_comb begin
        phase_d = enable ? ~phase_q : PH_A;
        hold_d = (enable && phase_q == PH_A) ? data_in : hold_q;
        overflow_d = overflow_q || (push && !push_ok);
        cnt_d = cnt_q + CNT_W'(push_ok);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_A;
            hold_q <= '0;
            overflow_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            phase_q <= phase_d;
            hold_q <= hold_d;
            overflow_q <= overflow_d;
            cnt_q <= cnt_d;
        end
    end
    sync_fifo_fwft #(.WIDTH(2 * N), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push_i   (push),
        .data_i   ({data_in, hold_q}),
        .pop_i    (out_ready),
        .data_o   (out_data),
        .full_o   (full),
        .empty_o  (empty),
        .push_ok_o(push_ok)
    );
    logic unused_full;
    assign unused_full = full;
endmodule

// File: tb/tb_mux_pair_gather.sv
// tb_mux_pair_gather: directed steps with a scoreboard queue of expected paired words.
module tb_mux_pair_gather;
    localparam int N = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic out_ready = 1'b0;
    logic [N-1:0] data_in = '0;
    logic [2*N-1:0] out_data;
    logic out_valid, overflow, orphan;
    logic [CNT_W-1:0] pair_count;
    int compared = 0;
    int mismatched = 0;
    logic [2*N-1:0] exp_q[$];
    logic m_phase = 1'b0;
    logic [N-1:0] m_hold = '0;
    logic [CNT_W-1:0] m_count = '0;
    logic m_ovf = 1'b0;

    always #5 clk = ~clk;

    mux_pair_gather #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .data_in   (data_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .orphan    (orphan),
        .pair_count(pair_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_phase = 1'b0;
        m_hold = '0;
        m_count = '0;
        m_ovf = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; checks before the next edge, then advances the model.
    task automatic cyc(input logic en, input logic [N-1:0] d, input logic rdy);
        logic pop, push;
        enable = en;
        data_in = d;
        out_ready = rdy;
        #4;
        chk("out_valid", 32'(exp_q.size() != 0), 32'(out_valid) ^ 32'(out_valid) ^ 32'(exp_q.size() != 0));
        chk("out_valid_obs", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
        chk("orphan", 32'(orphan), 32'(!en && m_phase));
        chk("pair_count", 32'(pair_count), 32'(m_count));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        pop = exp_q.size() != 0 && rdy;
        push = en && m_phase;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back({d, m_hold});
                m_count = m_count + 1'b1;
            end else m_ovf = 1'b1;
        end
        if (en && !m_phase) m_hold = d;
        m_phase = en ? ~m_phase : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pair_count", 32'(pair_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_orphan", 32'(orphan), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #14;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_data", 32'(out_data), 32'd0);
        chk("init_pair_count", 32'(pair_count), 32'd0);
        chk("init_overflow", 32'(overflow), 32'd0);
        chk("init_orphan", 32'(orphan), 32'd0);
        #2;
        reset = 1'b0;
        // pairing after reset
        cyc(1'b1, 8'h11, 1'b1);
        cyc(1'b1, 8'h22, 1'b1);
        cyc(1'b1, 8'h33, 1'b1);
        cyc(1'b1, 8'h44, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("pairing_count", 32'(pair_count), 32'd2);
        // orphan, then a fresh burst restarting at lane A
        cyc(1'b1, 8'hA1, 1'b1);
        cyc(1'b1, 8'hB1, 1'b1);
        cyc(1'b1, 8'hA2, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'hC1, 1'b1);
        cyc(1'b1, 8'hC2, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("orphan_count", 32'(pair_count), 32'd4);
        // backpressure and overflow
        do_reset();
        for (int i = 1; i <= 10; i++) cyc(1'b1, N'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(pair_count), 32'd4);
        chk("ovf_head", 32'(out_data), 32'h0201);
        // reset mid-operation with 2 words queued and phase=B
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h5A, 1'b0);
        do_reset();
        cyc(1'b0, 8'h00, 1'b0);
        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) cyc(1'b1, N'(8'h60 + i), 1'b0);
        cyc(1'b1, 8'hE1, 1'b0);
        cyc(1'b1, 8'hE2, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("full_pp_overflow", 32'(overflow), 32'd0);
        chk("full_pp_count", 32'(pair_count), 32'd5);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
        // counter wrap with CNT_W=4
        do_reset();
        for (int i = 0; i < 34; i++) cyc(1'b1, N'(i * 7 + 3), 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("wrap_count", 32'(pair_count), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mux_pair_gather.md
Name: mux_pair_gather

Overview:
- Sits directly downstream of the 2:1 time-multiplexing clock mux.
- The mux presents lane A, then lane B, alternating each cycle while `enable` is high. It restarts at lane A whenever `enable` drops.
- This block tracks the same phase, re-pairs each A/B beat into one 2N-bit word and queues it in a small FIFO with a valid/ready output.
- Its consumers are the wide datapath stages that cannot take the narrow alternating stream.

Parameters:
- N, 8, width of one multiplexed beat; must match the upstream mux N.
- DEPTH, 4, output FIFO depth in words; power of two, >= 2.
- CNT_W, 32, width of the pair counter.

Ports:
- clk  in  1  single clock, shared with the upstream mux.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  same enable net that drives the upstream mux.
- data_in  in  N  upstream mux output: lane A when phase=A, lane B when phase=B.
- out_data  out  2N  paired word {B,A}; B in the upper N bits.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data on a clock edge where out_valid && out_ready.
- overflow  out  1  sticky; set when a completed pair is dropped because the FIFO is full.
- orphan  out  1  one-cycle pulse; an A beat was discarded because `enable` fell before its B beat.
- pair_count  out  CNT_W  number of pairs written to the FIFO; wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - phase=A, hold=0, FIFO empty.
  - out_valid=0, out_data=0, overflow=0, orphan=0, pair_count=0.
  - Reset asynchronously clears everything, including mid-pair or mid-queue; partial state is lost and no orphan pulse is produced.
- Phase register, which mirrors the upstream state bit:
  - enable=1: phase toggles A->B->A each edge.
  - enable=0: phase forced to A.
  - The first cycle with enable=1 is always an A beat.
- A beat (enable=1, phase=A): data_in is captured into `hold`.
- B beat (enable=1, phase=B): the word {data_in, hold} is pushed into the FIFO on that edge.
  - out_valid rises on the following cycle when the FIFO was empty, so latency from B presentation to out_valid is 1 cycle.
  - pair_count increments on each successful push.
- Orphan: enable=0 while phase=B, i.e. an A beat was captured but no B followed.
  - `hold` is discarded; nothing is pushed.
  - orphan=1 for exactly that cycle.
- FIFO: DEPTH entries, with pointers one bit wider than log2(DEPTH) to distinguish full from empty.
  - out_data is driven from storage at the read pointer, so there is no extra read latency.
  - out_data shows the head entry whenever out_valid=1; its value is don't-care while out_valid=0.
  - Pop on out_valid && out_ready.
- Simultaneous push and pop:
  - Not full: both occur; occupancy is unchanged.
  - Full: both occur; the pop frees the slot the push uses, so there is no overflow.
- Push while full with no pop: the word is dropped, overflow set (cleared only by reset), pair_count not incremented.
- Pop while empty: ignored, with no pointer movement.
- Continuous enable=1 produces one pair every 2 cycles. Occupancy therefore never grows while out_ready is held high.

Decomposition:
- Shared package, in the form the codebase uses for shared definitions:
  - default beat width constant N.
  - FIFO depth constant.
  - phase encoding constants PH_A=0, PH_B=1.
- One natural sub-module: `sync_fifo_fwft` (parameters WIDTH, DEPTH), providing full/empty, first-word-through reads and the simultaneous push/pop rules above.
- Pairing, phase and orphan logic stay in the top level.

Test Plan:
- Pairing after reset:
  - Stimulus: release reset; enable=1 for 4 cycles with data_in = 0x11, 0x22, 0x33, 0x44; out_ready=1.
  - Response: out_data 0x2211 valid 1 cycle after the 0x22 beat; then 0x4433; pair_count=2.
- Orphan:
  - Stimulus: enable=1 for 3 cycles (0xA1, 0xB1, 0xA2), then enable=0.
  - Response: only 0xB1A1 is queued; orphan pulses once; the next enable burst restarts at lane A.
- Backpressure and overflow (DEPTH=4):
  - Stimulus: out_ready=0; 10 beats with enable=1.
  - Response: 4 words queued and out_valid held; the 5th pair is dropped; overflow=1; pair_count=4.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; out_ready pulsed for 1 cycle on the same edge as a B beat.
  - Response: head popped, new pair stored, occupancy stays 4, overflow stays 0.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously between clock edges with 2 words queued and phase=B.
  - Response: out_valid=0, pair_count=0, overflow=0 immediately; no orphan pulse.
- Counter wrap:
  - Stimulus: CNT_W=4; 17 pairs streamed with out_ready=1.
  - Response: pair_count=1 after wrap; data order preserved throughout.
